// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-port data-memory responder with wait states
//
// Terminates the core's data-memory request/ready port. One request is
// accepted at a time, held for WAIT_CYCLES wait states, then completed with a
// one-cycle ready pulse carrying read data and an error flag.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_BASE    byte address of word 0 (aligned to DEPTH_WORDS*4)
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports:
//   clk_i         clock, rising edge
//   rst_n_i       synchronous active-low reset
//   dmem_valid_i  request present (sampled only in IDLE)
//   dmem_we_i     1 = write, 0 = read
//   dmem_addr_i   byte address
//   dmem_wdata_i  write data, lane i = bits [8i+7:8i]
//   dmem_wstrb_i  byte-lane write enables (ignored on reads)
//   dmem_rdata_o  read data, nonzero only during the ready pulse
//   dmem_ready_o  one-cycle completion pulse
//   dmem_err_o    error flag, set only during the ready pulse

module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dmem_valid_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        dmem_err_o
);

  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        req_we_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_wstrb_q;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             capture;
  logic             enter_resp;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_wstrb;
  logic [31:0]      acc_offset;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_err;

  assign capture = (state_q == ST_IDLE) && dmem_valid_i;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dmem_valid_i) begin
          cnt_d   = WAIT_LD;
          state_d = (WAIT_LD == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // With zero wait states the access happens on the capture edge itself, so
  // the operands come straight from the port; otherwise from the request
  // registers, which makes later input changes irrelevant.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = dmem_we_i;
      acc_addr  = dmem_addr_i;
      acc_wdata = dmem_wdata_i;
      acc_wstrb = dmem_wstrb_i;
    end else begin
      acc_we    = req_we_q;
      acc_addr  = req_addr_q;
      acc_wdata = req_wdata_q;
      acc_wstrb = req_wstrb_q;
    end
  end

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

  // Unsigned offset: an address below the base wraps to a large value and
  // lands in the out-of-range check. Because the base is aligned to the
  // window size, the window test reduces to the upper offset bits being zero.
  assign acc_offset = acc_addr - ADDR_BASE;
  assign acc_idx    = acc_offset[IDX_W+1:2];
  assign acc_err    = (acc_offset[31:IDX_W+2] != '0) || (acc_offset[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      req_wstrb_q <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        req_we_q    <= dmem_we_i;
        req_addr_q  <= dmem_addr_i;
        req_wdata_q <= dmem_wdata_i;
        req_wstrb_q <= dmem_wstrb_i;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'd0 : mem_q[acc_idx];
      end else begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Storage is never cleared; a reset on the RESP-entry edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign dmem_ready_o = (state_q == ST_RESP);
  assign dmem_rdata_o = rdata_q;
  assign dmem_err_o   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Single-port data-memory responder that terminates the core's data-memory request/ready interface. It accepts one request at a time from the core's MEM stage, applies a programmable number of wait states, and performs byte-strobed writes or full-word reads into an internal word array. It is the memory-side counterpart of the core's data port, used in simulation tops and small FPGA builds.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two, ≥ 4.
- ADDR_BASE, 32'h0000_1000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 1: extra wait states per access, 0..15.
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- dmem_valid_i  in  1  request present.
- dmem_we_i  in  1  1 = write, 0 = read.
- dmem_addr_i  in  32  byte address.
- dmem_wdata_i  in  32  write data; lane i = bits [8i+7:8i].
- dmem_wstrb_i  in  4  byte-lane write enables; ignored on reads.
- dmem_rdata_o  out  32  read data, valid only while dmem_ready_o = 1.
- dmem_ready_o  out  1  one-cycle completion pulse.
- dmem_err_o  out  1  error flag, valid only while dmem_ready_o = 1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on dmem_valid_i = 1, capture we, addr, wdata, wstrb into request registers; load wait counter with WAIT_CYCLES; go WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: decrement counter each cycle; when counter reaches 1 (i.e. after WAIT_CYCLES cycles in WAIT), go RESP.
- On the edge entering RESP: perform access using captured request only; register dmem_rdata_o and dmem_err_o.
- RESP: dmem_ready_o = 1 for exactly this cycle; unconditionally go IDLE next edge. No new request is captured in RESP.
- Index = (addr − ADDR_BASE) >> 2, $clog2(DEPTH_WORDS) bits, unsigned.
- Error when addr < ADDR_BASE, addr ≥ ADDR_BASE + DEPTH_WORDS*4, or addr[1:0] ≠ 0. On error: no array update, dmem_rdata_o = 0, dmem_err_o = 1.
- Write: for each i with wstrb[i] = 1, array[index] lane i ← wdata lane i; other lanes unchanged. wstrb = 4'b0000 completes normally with no update. dmem_rdata_o = 0 on writes.
- Read: dmem_rdata_o = array[index] as of the edge entering RESP.
- Input changes after capture (including dmem_valid_i dropping) are ignored; a captured request always completes with one ready pulse.
- Array contents are not cleared by reset and persist across reset.

## Timing
- Reset (rst_n_i = 0 at an edge): state IDLE, counter 0, dmem_ready_o = 0, dmem_err_o = 0, dmem_rdata_o = 0. Reset during WAIT or RESP aborts the request; an aborted write does not update the array if reset occurs before the RESP-entry edge.
- Request sampled in IDLE at edge T → dmem_ready_o high in cycle T+1+WAIT_CYCLES (WAIT_CYCLES = 0: ready in the cycle after capture).
- Outside the RESP cycle: dmem_ready_o = 0, dmem_err_o = 0, dmem_rdata_o = 0.
- The initiator holds dmem_valid_i until it observes ready. The responder returns to IDLE after RESP. It samples the next request one cycle after the ready pulse. A valid held high across the RESP cycle is captured in the following IDLE cycle as a new request.
- Throughput: one access per WAIT_CYCLES + 2 cycles.
- Read-after-write to the same word returns the written data on the next access, with no hazard window.

## Test plan
- WAIT_CYCLES = 0: write 32'hDEAD_BEEF, wstrb 4'hF to ADDR_BASE+8, then read ADDR_BASE+8 → each ready exactly 1 cycle after capture; read data 32'hDEAD_BEEF, err = 0.
- Byte strobes: word preloaded with 32'h1122_3344, write 32'hAABB_CCDD with wstrb 4'b0101 → read returns 32'h11BB_33DD. Write with wstrb 4'b0000 → word unchanged.
- WAIT_CYCLES = 3: read captured at edge T → ready only in cycle T+4. Toggle dmem_addr_i and drop valid during WAIT → data comes from the originally captured address.
- Errors: read ADDR_BASE−4, read ADDR_BASE + DEPTH_WORDS*4, and write ADDR_BASE+2 → each gives a ready pulse with err = 1 and rdata = 0; a subsequent read of ADDR_BASE shows no corruption.
- Back-to-back: valid held high for 3 requests with WAIT_CYCLES = 1 → ready pulses spaced exactly 3 cycles apart, each returning correct data.
- Reset mid-op: assert rst_n_i = 0 during WAIT of a write → outputs 0 next cycle, state IDLE, target word unchanged. Data written before reset is still readable after reset.
